// File: rtl/acc_fp_pkg.sv
// Shared types and field widths for the FP accumulate loop.
// State encoding and the 16-bit accumulator format live here.
package acc_fp_pkg;

    localparam int ACC_W  = 16;
    localparam int EXP_W  = 4;
    localparam int MAN_W  = 11;
    localparam int PMAN_W = 16;

    localparam logic [ACC_W-1:0] ACC_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/acc_fp_tmo.sv
// Watchdog for one loop pass: counts cycles while enabled.
// expire pulses on the last allowed cycle of a pass.
module acc_fp_tmo #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/acc_fp_seq.sv
// FP accumulate loop sequencer: one product in flight,
// accumulator feedback, final sum on a valid/ready port.
module acc_fp_seq
    import acc_fp_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sgn,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [PMAN_W-1:0] in_man,
    output logic              dp_issue,
    output logic [ACC_W-1:0]  dp_ops,
    output logic              dp_mul_sgn,
    output logic [EXP_W-1:0]  dp_mul_exp,
    output logic [PMAN_W-1:0] dp_mul_man,
    input  logic              dp_res_valid,
    input  logic [ACC_W-1:0]  dp_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy,
    output logic              err
);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   cnt_inc;
    logic               hs;
    logic               tmo_en;
    logic               tmo_exp;

    assign in_ready = (state == ISSUE);
    assign hs       = in_valid && in_ready;
    assign cnt_inc  = cnt + LEN_W'(1);
    assign tmo_en   = (state == WAIT);

    acc_fp_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (hs),
        .en     (tmo_en),
        .expire (tmo_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= ACC_ZERO;
            cnt        <= '0;
            len        <= '0;
            dp_issue   <= 1'b0;
            dp_ops     <= ACC_ZERO;
            dp_mul_sgn <= 1'b0;
            dp_mul_exp <= '0;
            dp_mul_man <= '0;
            out_valid  <= 1'b0;
            out_data   <= ACC_ZERO;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            dp_issue <= 1'b0;
            // A result racing the watchdog is treated as stray.
            if (tmo_exp || (dp_res_valid && state != WAIT)) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len  <= cfg_len;
                        acc  <= ACC_ZERO;
                        cnt  <= '0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (cfg_len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= ACC_ZERO;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        dp_mul_sgn <= in_sgn;
                        dp_mul_exp <= in_exp;
                        dp_mul_man <= in_man;
                        dp_ops     <= acc;
                        dp_issue   <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (tmo_exp || dp_res_valid) begin
                        cnt <= cnt_inc;
                        if (!tmo_exp) begin
                            acc <= dp_res;
                        end
                        if (cnt_inc == len) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= tmo_exp ? acc : dp_res;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_fp_seq.sv
// Bench for acc_fp_seq: transaction model, adder responder,
// directed runs with literal expectations.
module tb_acc_fp_seq;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sgn = 1'b0;
    logic [3:0]  in_exp = 4'd0;
    logic [15:0] in_man = 16'd0;
    logic        dp_issue;
    logic [15:0] dp_ops;
    logic        dp_mul_sgn;
    logic [3:0]  dp_mul_exp;
    logic [15:0] dp_mul_man;
    logic        dp_res_valid = 1'b0;
    logic [15:0] dp_res = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
    logic        err;

    acc_fp_seq #(
        .LEN_W   (8),
        .TMO_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sgn       (in_sgn),
        .in_exp       (in_exp),
        .in_man       (in_man),
        .dp_issue     (dp_issue),
        .dp_ops       (dp_ops),
        .dp_mul_sgn   (dp_mul_sgn),
        .dp_mul_exp   (dp_mul_exp),
        .dp_mul_man   (dp_mul_man),
        .dp_res_valid (dp_res_valid),
        .dp_res       (dp_res),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Per-product stimulus: product, adder delay (0 = never), sum.
    logic [20:0] prod_tab[64];
    int          lat_tab[64];
    logic [15:0] res_tab[64];

    // Adder/normaliser stand-in, plus stray-pulse injection.
    int          cd = 0;
    int          gi = 0;
    logic [15:0] cres = 16'd0;
    logic        stray_req = 1'b0;
    logic        stray_ack = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dp_res_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dp_res_valid = 1'b1;
                    dp_res = cres;
                end
            end
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                dp_res_valid = 1'b1;
                dp_res = 16'hDEAD;
            end
            if (dp_issue) begin
                cd = lat_tab[gi];
                cres = res_tab[gi];
                gi++;
            end
        end
    end

    // Transaction model: one product in flight, watchdog window,
    // sticky error, final sum held until accepted.
    logic [15:0] m_acc;
    logic        m_err, m_busy, m_ov, m_inf, m_iss;
    int          m_w;
    logic [7:0]  m_cnt, m_len;
    int          ci = 0;
    logic [15:0] ops_log[$];

    always @(negedge clk) begin
        logic rdy, b0, fin;
        if (!rst_n) begin
            m_acc = 16'd0; m_err = 0; m_busy = 0; m_ov = 0;
            m_inf = 0; m_iss = 0; m_w = 0; m_cnt = 0; m_len = 0;
        end else begin
            rdy = m_busy && !m_ov && !m_inf;
            b0 = m_busy;
            check("in_ready", in_ready, rdy);
            check("dp_issue", dp_issue, m_iss);
            check("out_valid", out_valid, m_ov);
            check("busy", busy, m_busy);
            check("err", err, m_err);
            if (m_ov) check("out_data", out_data, m_acc);
            if (dp_issue) begin
                check("dp_ops", dp_ops, m_acc);
                check("dp_mul", {dp_mul_sgn, dp_mul_exp, dp_mul_man},
                      prod_tab[ci]);
                ops_log.push_back(dp_ops);
                ci++;
            end
            m_iss = 0;
            if (m_ov && out_ready) begin
                m_ov = 0;
                m_busy = 0;
            end
            if (m_inf) begin
                fin = 0;
                if (m_w == TMO - 1) begin
                    m_err = 1;
                    fin = 1;
                end else if (dp_res_valid) begin
                    m_acc = dp_res;
                    fin = 1;
                end else begin
                    m_w++;
                end
                if (fin) begin
                    m_inf = 0;
                    m_cnt++;
                    if (m_cnt == m_len) m_ov = 1;
                end
            end else if (dp_res_valid) begin
                m_err = 1;
            end
            if (rdy && in_valid) begin
                m_inf = 1;
                m_w = 0;
                m_iss = 1;
            end
            if (start && !b0) begin
                m_acc = 16'd0; m_err = 0; m_cnt = 0;
                m_len = cfg_len; m_busy = 1;
                m_ov = (cfg_len == 8'd0);
            end
        end
    end

    int pi = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        check("in_ready_timeout", 0, 1);
    endtask

    task automatic wait_ov();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check("out_valid_timeout", 0, 1);
    endtask

    task automatic send(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            repeat (gap) tick();
            in_valid = 1'b1;
            {in_sgn, in_exp, in_man} = prod_tab[pi];
            wait_rdy();
            tick();
            in_valid = 1'b0;
            pi++;
        end
    endtask

    task automatic run(input logic [7:0] len, input int gap,
                       input int hold, input logic [15:0] fin);
        int c0;
        c0 = ci;
        start = 1'b1;
        cfg_len = len;
        tick();
        start = 1'b0;
        cfg_len = 8'hAA;
        if (len == 8'd0) check("len0_done", out_valid, 1);
        send(len, gap);
        wait_ov();
        repeat (hold) tick();
        check("final_sum", out_data, fin);
        check("n_issue", ci - c0, len);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end

    initial begin
        int b;
        for (int i = 0; i < 64; i++) begin
            prod_tab[i] = {i[0], 4'(i + 1), 16'(i * 273 + 19)};
            lat_tab[i] = 2;
            res_tab[i] = 16'(16'h3000 + i * 33);
        end
        lat_tab[0] = 3; res_tab[0] = 16'h3800;
        lat_tab[1] = 3; res_tab[1] = 16'h4000;
        lat_tab[2] = 3; res_tab[2] = 16'h4200;
        lat_tab[3] = 2; lat_tab[4] = 5;
        lat_tab[5] = 1; lat_tab[6] = 7;
        lat_tab[7] = 4; lat_tab[8] = 0; lat_tab[9] = 2;
        lat_tab[13] = 8;

        // reset values
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_dp_issue", dp_issue, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_dp_ops", dp_ops, 16'h0000);
        check("rst_dp_mul", {dp_mul_sgn, dp_mul_exp, dp_mul_man}, 0);

        // three-product dot product
        b = ops_log.size();
        run(8'd3, 0, 0, 16'h4200);
        check("ops0", ops_log[b], 16'h0000);
        check("ops1", ops_log[b + 1], 16'h3800);
        check("ops2", ops_log[b + 2], 16'h4000);

        // empty dot product
        run(8'd0, 0, 0, 16'h0000);

        // input gaps, consumer stall
        run(8'd4, 3, 5, res_tab[6]);

        // watchdog on product 2 of 3
        b = ops_log.size();
        run(8'd3, 1, 0, res_tab[9]);
        check("tmo_err", err, 1);
        check("tmo_acc_kept", ops_log[b + 2], res_tab[7]);
        run(8'd1, 0, 0, res_tab[10]);
        check("err_cleared", err, 0);

        // stray result while waiting for a product
        b = ops_log.size();
        start = 1'b1;
        cfg_len = 8'd2;
        tick();
        start = 1'b0;
        send(1, 0);
        wait_rdy();
        stray_req = ~stray_req;
        repeat (3) tick();
        check("stray_err", err, 1);
        send(1, 0);
        wait_ov();
        check("stray_acc", ops_log[b + 1], res_tab[11]);
        check("stray_final", out_data, res_tab[12]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset while a product is in flight
        start = 1'b1;
        cfg_len = 8'd2;
        tick();
        start = 1'b0;
        send(1, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_dp_ops", dp_ops, 16'h0000);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("late_res_err", err, 1);
        check("late_res_busy", busy, 0);
        run(8'd0, 0, 0, 16'h0000);
        check("late_res_cleared", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
